// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Handshake/data bundle between the EX-stage issue logic and the iterative
// multiply/divide unit.
//   start      launch an operation (sampled only while busy=0)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcA/srcB  rs/rt operands; srcA is also the MTHI/MTLO data
//   hiWrite    MTHI strobe
//   loWrite    MTLO strobe
//   hi/lo      architectural HI/LO registers
//   busy       operation in progress
//   done       one-cycle pulse when HI/LO take a result
//   divByZero  flag of the last completed operation
// master: issue side, slave: the unit itself.
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             divByZero;

  modport master (
    output start, op, srcA, srcB, hiWrite, loWrite,
    input  hi, lo, busy, done, divByZero
  );

  modport slave (
    input  start, op, srcA, srcB, hiWrite, loWrite,
    output hi, lo, busy, done, divByZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative MIPS multiply/divide unit holding the HI/LO registers.
// MULT/MULTU use a shift-add multiplier on a 2*WIDTH accumulator, DIV/DIVU a
// restoring shift-subtract divider; both take WIDTH iterations plus one
// sign-fix cycle, so every operation completes WIDTH+2 cycles after start.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (discards any in-flight operation)
//   bus    mult_div_unit_if.slave: start/op/srcA/srcB/hiWrite/loWrite in,
//          hi/lo/busy/done/divByZero out
//
// Build option:
//   MULTDIV_SIGNED_EN  when defined, MULT/DIV use signed semantics. When
//                      undefined, op[0] is ignored (MULT acts as MULTU, DIV as
//                      DIVU) and no abs/negate logic exists; timing is the same.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT              stateReg;
  logic               isDivReg;
  logic [WIDTH-1:0]   opAReg;      // multiplicand / dividend magnitude
  logic [WIDTH-1:0]   opBReg;      // multiplier / divisor magnitude
  logic [2*WIDTH-1:0] accReg;      // product accumulator; low half is quotient for divide
  logic [WIDTH-1:0]   remReg;      // partial remainder
  logic [CW-1:0]      cntReg;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               busyReg;
  logic               doneReg;
  logic               divByZeroReg;

  // -------------------------------------------------------------------------
  // Operand conditioning at issue
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

`ifdef MULTDIV_SIGNED_EN
  logic             signedOp;
  logic             signAReg;
  logic             signBReg;
  logic [WIDTH-1:0] rawAReg;       // original srcA, returned in HI on divide-by-zero

  assign signedOp = ~bus.op[0];
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  assign magA = (signedOp && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
  assign magB = (signedOp && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
`else
  logic unusedOpBit;

  assign unusedOpBit = bus.op[0];
  assign magA = bus.srcA;
  assign magB = bus.srcB;
`endif

  // -------------------------------------------------------------------------
  // Per-iteration datapaths
  // -------------------------------------------------------------------------
  logic [WIDTH:0] mulSum;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] remDiff;
  logic           remFits;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  assign mulSum   = {1'b0, accReg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (accReg[0] ? opAReg : {WIDTH{1'b0}})};

  // Restoring divide: bring in the next dividend bit; the partial remainder
  // stays below the divisor, so the shifted value needs WIDTH+1 bits and the
  // top bit of the difference acts as the borrow.
  assign remShift = {remReg, accReg[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, opBReg};
  assign remFits  = ~remDiff[WIDTH];

  // -------------------------------------------------------------------------
  // Final sign correction
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
  logic [WIDTH-1:0]   zeroDivHi;

`ifdef MULTDIV_SIGNED_EN
  always_comb begin
    prodFix = (signAReg ^ signBReg) ? -accReg : accReg;
    quotFix = (signAReg ^ signBReg) ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
    // Truncating division: remainder follows the dividend's sign.
    remFix  = signAReg ? -remReg : remReg;
  end
  assign zeroDivHi = rawAReg;
`else
  assign prodFix   = accReg;
  assign quotFix   = accReg[WIDTH-1:0];
  assign remFix    = remReg;
  assign zeroDivHi = opAReg;
`endif

  // -------------------------------------------------------------------------
  // Control FSM and HI/LO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      hiReg        <= '0;
      loReg        <= '0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      divByZeroReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          // MTHI/MTLO; a same-cycle start still launches and FIX overwrites later.
          if (bus.hiWrite) hiReg <= bus.srcA;
          if (bus.loWrite) loReg <= bus.srcA;
          if (bus.start) begin
            isDivReg <= bus.op[1];
            opAReg   <= magA;
            opBReg   <= magB;
            accReg   <= {{WIDTH{1'b0}}, (bus.op[1] ? magA : magB)};
            remReg   <= '0;
            cntReg   <= '0;
`ifdef MULTDIV_SIGNED_EN
            signAReg <= signedOp & bus.srcA[WIDTH-1];
            signBReg <= signedOp & bus.srcB[WIDTH-1];
            rawAReg  <= bus.srcA;
`endif
            busyReg  <= 1'b1;
            stateReg <= RUN;
          end
        end

        RUN: begin
          if (isDivReg) begin
            remReg <= remFits ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
            accReg <= {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-2:0], remFits};
          end else begin
            accReg <= {mulSum, accReg[WIDTH-1:1]};
          end
          cntReg <= cntReg + 1'b1;
          if (cntReg == CW'(WIDTH - 1)) stateReg <= FIX;
        end

        FIX: begin
          if (isDivReg) begin
            if (opBReg == '0) begin
              hiReg        <= zeroDivHi;
              loReg        <= '1;
              divByZeroReg <= 1'b1;
            end else begin
              hiReg        <= remFix;
              loReg        <= quotFix;
              divByZeroReg <= 1'b0;
            end
          end else begin
            {hiReg, loReg} <= prodFix;
            divByZeroReg   <= 1'b0;
          end
          busyReg  <= 1'b0;
          doneReg  <= 1'b1;
          stateReg <= IDLE;
        end

        default: stateReg <= IDLE;
      endcase
    end
  end

  assign bus.hi        = hiReg;
  assign bus.lo        = loReg;
  assign bus.busy      = busyReg;
  assign bus.done      = doneReg;
  assign bus.divByZero = divByZeroReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Scoreboard bench for mult_div_unit: stimulus pushes the reference result
// (plain integer arithmetic) into a queue, a monitor pops and compares on
// every done pulse, including result latency.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_div_unit;
  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          issueCyc;
    string       name;
  } expT;

  expT sbQ[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain integer arithmetic.
  function automatic expT model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    expT         e;
    logic        sgn;
    logic [63:0] p;
    longint      sa;
    longint      sb;
`ifdef MULTDIV_SIGNED_EN
    sgn = ~op[0];
`else
    sgn = 1'b0;
`endif
    e.dbz      = 1'b0;
    e.issueCyc = 0;
    e.name     = "";
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op[1]) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'd0, a} * {32'd0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else if (sgn) begin
      e.lo = 32'(sa / sb);
      e.hi = 32'(sa % sb);
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: one comparison set per done pulse.
  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && bus.done === 1'b1) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_done cycle=%0d", cyc);
        end else begin
          e = sbQ.pop_front();
          chk($sformatf("%s_hi", e.name), 64'(bus.hi), 64'(e.hi));
          chk($sformatf("%s_lo", e.name), 64'(bus.lo), 64'(e.lo));
          chk($sformatf("%s_dbz", e.name), 64'(bus.divByZero), 64'(e.dbz));
          chk($sformatf("%s_latency", e.name), 64'(cyc - e.issueCyc), 64'(LAT));
          $display("txn %s hi=%08h lo=%08h dbz=%0b", e.name, bus.hi, bus.lo, bus.divByZero);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    expT e;
    e          = model(op, a, b);
    e.issueCyc = cyc;
    e.name     = name;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.srcA   = a;
    bus.srcB   = b;
    sbQ.push_back(e);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.hiWrite = 1'b0;
    bus.loWrite = 1'b0;
    bus.srcA    = $urandom;
    bus.srcB    = $urandom;
  endtask

  // Issue and step to the done cycle checking busy/done every cycle.
  task automatic runTimed(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
    issue(op, a, b, name);
    for (int k = 1; k <= LAT; k++) begin
      chk($sformatf("%s_busy@%0d", name, k), 64'(bus.busy), 64'(k <= WIDTH + 1));
      chk($sformatf("%s_done@%0d", name, k), 64'(bus.done), 64'(k == LAT));
      if (k < LAT) @(negedge clk);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((sbQ.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sbQ.size()), 64'd0);
  endtask

  initial begin : stim
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;

    bus.start = 1'b0; bus.op = 2'b00; bus.srcA = '0; bus.srcB = '0;
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_dbz", 64'(bus.divByZero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed chain, each issued in the previous op's done cycle.
    runTimed(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
    runTimed(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
    runTimed(2'b11, 32'd100, 32'd7, "divu_100d7");
    runTimed(2'b11, 32'h1234_5678, 32'd0, "divu_by0");
    runTimed(2'b01, 32'd2, 32'd3, "multu_2x3");
    runTimed(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    runTimed(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
    runTimed(2'b10, 32'hFFFF_FFF9, 32'd0, "div_m7_by0");
    runTimed(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7dm2");
    runTimed(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    waitIdle();

    // MTHI / MTLO while idle.
    bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.srcA = 32'h0BAD_F00D;
    @(negedge clk);
    bus.loWrite = 1'b0; bus.srcA = 32'hDEAD_BEEF;
    chk("mthlo_hi", 64'(bus.hi), 64'h0BAD_F00D);
    chk("mthlo_lo", 64'(bus.lo), 64'h0BAD_F00D);
    @(negedge clk);
    bus.hiWrite = 1'b0;
    chk("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    chk("mthi_lo_kept", 64'(bus.lo), 64'h0BAD_F00D);

    // Writes and starts while busy are ignored.
    issue(2'b01, 32'h0000_1000, 32'h0000_0010, "multu_busyign");
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.hiWrite = 1'b1; bus.loWrite = 1'b1;
    bus.srcA = 32'h1111_1111; bus.srcB = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    chk("busywr_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    chk("busywr_lo", 64'(bus.lo), 64'h0BAD_F00D);
    repeat (14) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle();

    // Start and MTHI in the same idle cycle: write lands, op still runs.
    bus.hiWrite = 1'b1;
    issue(2'b01, 32'hCAFE_0001, 32'd3, "multu_withmthi");
    chk("startwr_hi", 64'(bus.hi), 64'hCAFE_0001);
    waitIdle();

    // Reset in cycle 10 of a MULTU.
    issue(2'b01, 32'h0001_2345, 32'h0000_0678, "multu_reset");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sbQ.delete();
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    runTimed(2'b11, 32'd1000, 32'd33, "divu_afterrst");

    // Randomized ops, chained back-to-back.
    for (int i = 0; i < 30; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rB = 32'd0;
        1:       rB = 32'hFFFF_FFFF;
        2:       rB = 32'($urandom_range(1, 15));
        default: rB = 32'($urandom);
      endcase
      runTimed(rOp, rA, rB, $sformatf("rnd%0d_op%0d", i, rOp));
    end
    waitIdle();
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 64'(sbQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
